// File: rtl/dac8_pkg.sv
// Shared constants and FSM state type for the 8-channel DAC sample arbiter.
// Imported by the arbiter top and its pair-buffer sub-module.
package dac8_pkg;

    localparam int num_links = 4;
    localparam int num_chans = 8;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/sample_pair_buffer.sv
// Two-entry (left, right) FIFO holding one receiver's stereo pair.
// Ports: clk, reset, flush, wr_en/wr_data in, rd_en pop, head_data/next_data
// peek at oldest and second-oldest entry, full/empty status.
module sample_pair_buffer
    import dac8_pkg::*;
#(
    parameter int sample_width = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [sample_width-1:0] wr_data,
    input  logic                    rd_en,
    output logic [sample_width-1:0] head_data,
    output logic [sample_width-1:0] next_data,
    output logic                    full,
    output logic                    empty
);

    logic [sample_width-1:0] mem_q [2];
    logic [sample_width-1:0] mem_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;
    logic                    do_wr;
    logic                    do_rd;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign head_data = mem_q[rd_ptr_q];
    assign next_data = mem_q[~rd_ptr_q];

    // Flush has priority: a word arriving on the flush cycle is discarded.
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_wr) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_rd) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_wr} - {1'b0, do_rd};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dac8_sample_arbiter.sv
// Merges four stereo receiver links into one 8-channel frame stream.
// Ports: clk, reset, in_enable/in_data/in_ready per link, out_enable/out_ready/
// out_data/out_chan/out_sof merged stream, overrun, resync_count, clear_status.
module dac8_sample_arbiter
    import dac8_pkg::*;
#(
    parameter int sample_width   = 24,
    parameter int timeout_cycles = 4096
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [num_links-1:0]                    in_enable,
    input  logic [num_links-1:0][sample_width-1:0]  in_data,
    output logic [num_links-1:0]                    in_ready,
    output logic                                    out_enable,
    input  logic                                    out_ready,
    output logic [sample_width-1:0]                 out_data,
    output logic [2:0]                              out_chan,
    output logic                                    out_sof,
    output logic [num_links-1:0]                    overrun,
    output logic [7:0]                              resync_count,
    input  logic                                    clear_status
);

    localparam int tw = $clog2(timeout_cycles + 1);

    state_t                  state_q, state_d;
    logic                    out_enable_q, out_enable_d;
    logic [sample_width-1:0] out_data_q, out_data_d;
    logic [2:0]              out_chan_q, out_chan_d;
    logic [num_links-1:0]    overrun_q, overrun_d;
    logic [7:0]              resync_q, resync_d;
    logic [tw-1:0]           timer_q, timer_d;

    logic [sample_width-1:0] head [num_links];
    logic [sample_width-1:0] nxt  [num_links];
    logic [num_links-1:0]    full;
    logic [num_links-1:0]    empty;
    logic [num_links-1:0]    pop;
    logic                    flush;
    logic [1:0]              link;
    logic [1:0]              link_next;
    logic                    all_full;
    logic                    any_word;
    logic [num_links-1:0]    ovr_evt;
    logic [7:0]              resync_base;

    for (genvar i = 0; i < num_links; i++) begin : g_buf
        sample_pair_buffer #(
            .sample_width(sample_width)
        ) u_buf (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .wr_en     (in_enable[i]),
            .wr_data   (in_data[i]),
            .rd_en     (pop[i]),
            .head_data (head[i]),
            .next_data (nxt[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    assign in_ready  = ~full;
    assign all_full  = &full;
    assign any_word  = |(~empty);
    assign ovr_evt   = in_enable & ~in_ready;
    assign link      = out_chan_q[2:1];
    assign link_next = link + 2'd1;

    always_comb begin
        state_d      = state_q;
        out_enable_d = out_enable_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        timer_d      = '0;
        flush        = 1'b0;
        pop          = '0;

        unique case (state_q)
            FILL: begin
                if (timer_q >= tw'(timeout_cycles)) begin
                    flush = 1'b1;
                end else if (all_full) begin
                    state_d = EMIT;
                end else if (any_word) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            EMIT: begin
                if (!out_enable_q) begin
                    out_enable_d = 1'b1;
                    out_data_d   = head[0];
                    out_chan_d   = 3'd0;
                end else if (out_ready) begin
                    pop[link] = 1'b1;
                    if (out_chan_q == 3'(num_chans - 1)) begin
                        out_enable_d = 1'b0;
                        out_chan_d   = 3'd0;
                        state_d      = FILL;
                    end else begin
                        out_chan_d = out_chan_q + 3'd1;
                        // Left just went out: right of same link is the
                        // second entry; after a right, next link's head.
                        out_data_d = out_chan_q[0] ? head[link_next]
                                                   : nxt[link];
                    end
                end
            end
            default: state_d = FILL;
        endcase

        // Clear applies to old state only; same-cycle events survive it.
        overrun_d   = (clear_status ? '0 : overrun_q) | ovr_evt;
        resync_base = clear_status ? 8'd0 : resync_q;
        resync_d    = resync_base;
        if (flush && resync_base != 8'hff) begin
            resync_d = resync_base + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            out_enable_q <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= 3'd0;
            overrun_q    <= '0;
            resync_q     <= 8'd0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            out_enable_q <= out_enable_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            overrun_q    <= overrun_d;
            resync_q     <= resync_d;
            timer_q      <= timer_d;
        end
    end

    assign out_enable   = out_enable_q;
    assign out_data     = out_data_q;
    assign out_chan     = out_chan_q;
    assign out_sof      = out_enable_q && (out_chan_q == 3'd0);
    assign overrun      = overrun_q;
    assign resync_count = resync_q;

endmodule

// File: tb/tb_dac8_sample_arbiter.sv
// Scoreboard bench for dac8_sample_arbiter: directed frames, overrun,
// timeout resync, mid-frame reset and coincident status clear.
module tb_dac8_sample_arbiter;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        in_enable = '0;
    logic [3:0][23:0]  in_data = '0;
    logic [3:0]        in_ready;
    logic              out_enable;
    logic              out_ready = 1'b1;
    logic [23:0]       out_data;
    logic [2:0]        out_chan;
    logic              out_sof;
    logic [3:0]        overrun;
    logic [7:0]        resync_count;
    logic              clear_status = 1'b0;

    dac8_sample_arbiter #(
        .sample_width   (24),
        .timeout_cycles (4096)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_enable    (in_enable),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_enable   (out_enable),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_chan     (out_chan),
        .out_sof      (out_sof),
        .overrun      (overrun),
        .resync_count (resync_count),
        .clear_status (clear_status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] data;
        logic [2:0]  chan;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        e;
    int          passed = 0;
    int          total = 0;
    logic [23:0] ml [4];
    logic [23:0] mr [4];
    int          mcnt [4] = '{0, 0, 0, 0};
    bit          toggle_mode = 1'b0;
    bit          seen_ch3 = 1'b0;
    bit          hold_pend = 1'b0;
    logic [23:0] hd;
    logic [2:0]  hc;
    int          cyc = 0;
    int          last_pop = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always begin
        @(posedge clk);
        #1;
        out_ready = toggle_mode ? ~out_ready : 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake, checks hold behaviour.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_en", out_enable, 1);
                check("hold_data", out_data, hd);
                check("hold_chan", out_chan, hc);
            end
            if (!out_enable) check("sof_idle", out_sof, 0);
            if (out_enable && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_word: got chan %0d data %0h expected none",
                             out_chan, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_chan", out_chan, e.chan);
                    check("out_sof", out_sof, e.chan == 3'd0);
                    if (!toggle_mode && e.chan != 3'd0)
                        check("consecutive", cyc - last_pop, 1);
                    last_pop = cyc;
                    if (e.chan == 3'd3) seen_ch3 = 1'b1;
                end
            end
            hold_pend = out_enable && !out_ready;
            hd = out_data;
            hc = out_chan;
        end
    end

    task automatic drive_word(int k, logic [23:0] d);
        @(posedge clk);
        #1;
        in_enable[k] = 1'b1;
        in_data[k]   = d;
        @(negedge clk);
        check($sformatf("in_ready%0d", k), in_ready[k], mcnt[k] < 2);
        if (mcnt[k] == 0) ml[k] = d;
        else if (mcnt[k] == 1) mr[k] = d;
        if (mcnt[k] < 2) mcnt[k]++;
        @(posedge clk);
        #1;
        in_enable[k] = 1'b0;
        if (mcnt[0] == 2 && mcnt[1] == 2 && mcnt[2] == 2 && mcnt[3] == 2) begin
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back('{data: ml[j], chan: 3'(2 * j)});
                exp_q.push_back('{data: mr[j], chan: 3'(2 * j + 1)});
                mcnt[j] = 0;
            end
        end
    endtask

    task automatic feed_frame(logic [23:0] base);
        for (int k = 0; k < 4; k++) begin
            drive_word(k, base + 24'(2 * k));
            drive_word(k, base + 24'(2 * k + 1));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_enable) && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        clear_status = 1'b1;
        @(posedge clk);
        #1;
        clear_status = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_enable", out_enable, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_out_sof", out_sof, 0);
        check("rst_overrun", overrun, 0);
        check("rst_resync", resync_count, 0);
        check("rst_in_ready", in_ready, 4'hf);

        // Basic frame, sink always ready.
        feed_frame(24'h000100);
        wait_drain();

        // Same frame with sink stalling every other cycle.
        toggle_mode = 1'b1;
        feed_frame(24'h000100);
        wait_drain();
        toggle_mode = 1'b0;

        // Third word on receiver 2 is dropped and flagged.
        drive_word(0, 24'h000100);
        drive_word(0, 24'h000101);
        drive_word(1, 24'h000102);
        drive_word(1, 24'h000103);
        drive_word(2, 24'h000104);
        drive_word(2, 24'h000105);
        drive_word(2, 24'h000bad);
        check("ovr_rx2", overrun, 4'b0100);
        drive_word(3, 24'h000106);
        drive_word(3, 24'h000107);
        wait_drain();
        check("ovr_rx2_hold", overrun, 4'b0100);
        pulse_clear();
        check("ovr_cleared", overrun, 4'b0000);

        // Partial frame times out and is flushed.
        drive_word(0, 24'h00aaa0);
        drive_word(0, 24'h00aaa1);
        drive_word(1, 24'h00aaa2);
        drive_word(1, 24'h00aaa3);
        repeat (4200) @(posedge clk);
        #1;
        check("resync_one", resync_count, 1);
        check("flush_in_ready", in_ready, 4'hf);
        check("flush_no_out", out_enable, 0);
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
        feed_frame(24'h000200);
        wait_drain();
        check("resync_still_one", resync_count, 1);

        // Reset after channel 3 has transferred.
        seen_ch3 = 1'b0;
        feed_frame(24'h000300);
        n = 0;
        while (!seen_ch3 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("ch3_seen", seen_ch3, 1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_out_enable", out_enable, 0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 4'hf);
        check("rel_resync", resync_count, 0);
        check("rel_out_enable", out_enable, 0);
        feed_frame(24'h000500);
        wait_drain();

        // Clear coincident with a fresh overrun on receiver 1.
        drive_word(3, 24'h000706);
        drive_word(3, 24'h000707);
        drive_word(3, 24'h000eee);
        check("ovr_rx3", overrun, 4'b1000);
        drive_word(1, 24'h000702);
        drive_word(1, 24'h000703);
        @(posedge clk);
        #1;
        clear_status = 1'b1;
        in_enable[1] = 1'b1;
        in_data[1]   = 24'h000ddd;
        @(negedge clk);
        check("in_ready1_full", in_ready[1], 0);
        @(posedge clk);
        #1;
        clear_status = 1'b0;
        in_enable[1] = 1'b0;
        check("ovr_clear_coinc", overrun, 4'b0010);
        drive_word(0, 24'h000700);
        drive_word(0, 24'h000701);
        drive_word(2, 24'h000704);
        drive_word(2, 24'h000705);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dac8_sample_arbiter.md
DAC8_SAMPLE_ARBITER -- requirements
Module: dac8_sample_arbiter

Interface
REQ-001 Parameter: sample_width, 24, bits per audio sample word.
REQ-002 Parameter: timeout_cycles, 4096, max cycles a partial frame may wait before resync.
REQ-003 Port: clk  input  1  single clock; reset is asynchronous and active-high.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_enable  input  4  per-receiver word valid (index 0 = slotdata[3] link .. 3 = slotdata[0] link).
REQ-006 Port: in_data  input  4 x sample_width  per-receiver sample word; left precedes right.
REQ-007 Port: in_ready  output  4  per-receiver accept.
REQ-008 Port: out_enable  output  1  merged word valid.
REQ-009 Port: out_ready  input  1  sink accept.
REQ-010 Port: out_data  output  sample_width  merged sample word.
REQ-011 Port: out_chan  output  3  channel index of out_data (0..7).
REQ-012 Port: out_sof  output  1  high with the channel-0 word of each frame.
REQ-013 Port: overrun  output  4  sticky per-receiver overrun flags.
REQ-014 Port: resync_count  output  8  saturating count of timeout resyncs.
REQ-015 Port: clear_status  input  1  one-cycle pulse clearing overrun and resync_count.

Function
REQ-016 Transfer on any port occurs only on a clk edge where enable and ready are both high.
REQ-017 Each receiver SHALL own a 2-entry pair buffer (L, R); in_ready[i] high iff that buffer is not full.
REQ-018 in_enable[i] high while in_ready[i] low SHALL set overrun[i] and drop the word.
REQ-019 States: FILL, EMIT. FILL -> EMIT when all four pair buffers are full; EMIT -> FILL after word 8 transfers.
REQ-020 In EMIT, words SHALL be emitted in order ch0..ch7: receiver k left = chan 2k, right = chan 2k+1.
REQ-021 out_enable, out_data, out_chan SHALL be registered and held stable until out_ready is sampled high.
REQ-022 Back-to-back EMIT words with out_ready tied high SHALL appear on consecutive cycles; first word one cycle after the FILL->EMIT edge.
REQ-023 A pair buffer SHALL free each entry on the cycle its word transfers out; receivers may refill during EMIT.
REQ-024 Timeout counter runs in FILL whenever at least one but not all buffers hold any word; reset to 0 otherwise.
REQ-025 Counter reaching timeout_cycles SHALL flush all four buffers, increment resync_count (saturate at 255), and stay in FILL.
REQ-026 An in_enable transfer on the same cycle as a flush SHALL be discarded.
REQ-027 clear_status coincident with a new overrun or resync SHALL leave the new event recorded.
REQ-028 out_sof SHALL be high only with chan 0 and only while out_enable is high.

Reset
REQ-029 On reset: state FILL, buffers empty, in_ready = 4'b1111 one cycle after release, out_enable = 0, out_data = 0, out_chan = 0, out_sof = 0, overrun = 0, resync_count = 0, timeout counter = 0.
REQ-030 Reset asserted mid-EMIT SHALL abort the frame; no partial frame is emitted after release.

Structure
REQ-031 Shared package dac8_pkg SHALL hold num_links = 4, num_chans = 8 and the state enum.
REQ-032 Pair buffer SHALL be a sub-module sample_pair_buffer, instantiated four times.

Verification
REQ-033 Reset, feed receivers 0..3 with L/R = 0x000100+2k / 0x000101+2k, out_ready=1 -> chans 0..7 out in order on 8 consecutive cycles, sof on chan 0.
REQ-034 Same frame, out_ready toggling 1,0 -> each word held during low cycles, order and data unchanged.
REQ-035 Receiver 2 pushes 3 words before EMIT -> overrun = 4'b0100, third word absent from output.
REQ-036 Receivers 0,1 full, 2,3 silent 4096 cycles -> resync_count = 1, buffers empty, no output.
REQ-037 Reset asserted after chan 3 emitted -> out_enable = 0 immediately; next full frame starts at chan 0.
REQ-038 clear_status pulse same cycle as overrun event on receiver 1 -> overrun = 4'b0010 afterwards.
